// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types for the load/store unit: access-size encodings, FSM state
// encoding and the alignment rule for an access.
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } lsu_state_e;

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (size == SZ_HALF) mis = off[0];
        if (size == SZ_WORD) mis = (off != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Bundles the core-side request/response handshake and the data-memory port.
//   slave  : the load/store unit's view (takes requests, drives memory)
//   master : the environment's view (issues requests, models the memory)
// -----------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational little-endian lane logic.
//   word_i     : memory word (read data for loads, old word for merges)
//   off_i      : byte offset within the word
//   size_i     : access size
//   unsigned_i : 1 = zero-extend loads, 0 = sign-extend
//   wdata_i    : right-justified store data
//   load_o     : selected lane extended to 32 bits
//   store_o    : word_i with the selected lane replaced by wdata_i
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = word_i[{off_i[1], 4'b0000} +: 16];
        load_o   = word_i;
        store_o  = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o  = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
                store_o = word_i;
                store_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o  = {{16{~unsigned_i & half_sel[15]}}, half_sel};
                store_o = word_i;
                store_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                load_o  = word_i;
                store_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Sequences one load/store at a time between the core and a word-wide data
// memory. Sub-word stores are done as read-modify-write.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/response handshake and data-memory port (slave view)
// Parameters:
//   MEM_WORDS   : memory depth in 32-bit words
//   CHECK_RANGE : 1 = out-of-range index is an error, 0 = index wraps
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 16,
    parameter bit          CHECK_RANGE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);

    lsu_state_e  state_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [31:0] old_word_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        req_err;
    logic [31:0] align_word;
    logic [31:0] load_val;
    logic [31:0] store_val;
    logic [31:0] wrap_idx;

    always_comb begin
        req_err = (bus.req_size == SZ_RSVD) || is_misaligned(bus.req_size, bus.req_addr[1:0]);
        if (CHECK_RANGE && ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS)) req_err = 1'b1;
    end

    // Loads extract from the live read data; merges use the word captured in READ.
    assign align_word = (state_q == S_READ) ? bus.mem_rd : old_word_q;

    lsu_lane_align u_lane_align (
        .word_i     (align_word),
        .off_i      (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .load_o     (load_val),
        .store_o    (store_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            old_word_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        we_q    <= bus.req_we;
                        size_q  <= bus.req_size;
                        uns_q   <= bus.req_unsigned;
                        wdata_q <= bus.req_wdata;
                        if (req_err) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                            state_q <= S_WRITE;
                        end else begin
                            state_q <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    old_word_q <= bus.mem_rd;
                    if (!we_q) begin
                        resp_rdata_q <= load_val;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wrap_idx = {2'b00, addr_q[31:2]} % MEM_WORDS;

    always_comb begin
        if (CHECK_RANGE) bus.mem_a = {addr_q[31:2], 2'b00};
        else             bus.mem_a = wrap_idx << 2;
    end

    // Write enable decodes straight from state so it falls with the async reset.
    assign bus.mem_we     = (state_q == S_WRITE);
    assign bus.mem_wd     = bus.mem_we ? store_val : 32'h0;
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(
        .MEM_WORDS   (16),
        .CHECK_RANGE (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] ram       [16];
    logic [31:0] model_mem [16];
    logic        poke_en = 1'b0;
    logic [3:0]  poke_idx = 4'd0;
    logic [31:0] poke_val = 32'h0;

    assign bus.mem_rd = ram[bus.mem_a[5:2]];

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_a[5:2]] <= bus.mem_wd;
        else if (poke_en) ram[poke_idx] <= poke_val;
    end

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] last_rd;
    logic        last_err;

    // Reference: plain arithmetic on a word array, little-endian lanes.
    function automatic void model_req(input logic we, input logic [1:0] size, input logic uns,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      output logic err, output logic [31:0] rdata,
                                      output int lat, output int nwrites);
        longint unsigned word, mask, v;
        int sh, nbits;
        int unsigned idx;
        idx = addr / 4;
        sh = (addr % 4) * 8;
        err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0) || (idx >= 16);
        rdata = 32'h0;
        nwrites = 0;
        lat = 1;
        if (err) return;
        nbits = 8 << size;
        mask = (64'd1 << nbits) - 1;
        word = 64'(model_mem[idx]);
        if (!we) begin
            v = (word >> sh) & mask;
            if (!uns && v[nbits-1]) v = v - (64'd1 << nbits);
            rdata = v[31:0];
            lat = 2;
        end else begin
            model_mem[idx] = 32'((word & ~(mask << sh)) | ((64'(wdata) & mask) << sh));
            lat = (size == 2'd2) ? 2 : 3;
            nwrites = 1;
        end
    endfunction

    task automatic poke(input int idx, input logic [31:0] v);
        @(negedge clk);
        poke_en = 1'b1;
        poke_idx = 4'(idx);
        poke_val = v;
        @(posedge clk);
        #1 poke_en = 1'b0;
        model_mem[idx] = v;
    endtask

    task automatic do_req(input string name, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        logic exp_err, got_err;
        logic [31:0] exp_rd, got_rd, got_wd;
        int exp_lat, exp_wr, got_lat, wr_cnt;
        bit a_bad, rdy_bad;
        int unsigned idx;
        model_req(we, size, uns, addr, wdata, exp_err, exp_rd, exp_lat, exp_wr);
        idx = addr / 4;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before: got %b want 1", name, bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_size = size;
        bus.req_unsigned = uns;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        // Garbage on the request lines while busy must be ignored.
        bus.req_valid = 1'b0;
        bus.req_we = 1'($urandom);
        bus.req_size = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr = $urandom;
        bus.req_wdata = $urandom;
        got_lat = 0;
        wr_cnt = 0;
        a_bad = 0;
        rdy_bad = 0;
        got_err = 1'b0;
        got_rd = 32'h0;
        got_wd = 32'h0;
        for (int c = 1; c <= 6 && got_lat == 0; c++) begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) begin
                wr_cnt++;
                got_wd = bus.mem_wd;
            end
            if (!exp_err && bus.mem_a !== {addr[31:2], 2'b00}) a_bad = 1;
            if (bus.req_ready !== 1'b0) rdy_bad = 1;
            if (bus.resp_valid === 1'b1) begin
                got_lat = c;
                got_err = bus.resp_err;
                got_rd = bus.resp_rdata;
            end
        end
        last_rd = got_rd;
        last_err = got_err;
        n_checks++;
        if (got_lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, got_lat, exp_lat);
        end
        n_checks++;
        if (got_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s resp_err: got %b want %b", name, got_err, exp_err);
        end
        n_checks++;
        if (got_rd !== exp_rd) begin
            n_fail++;
            $display("FAIL %s resp_rdata: got %h want %h", name, got_rd, exp_rd);
        end
        n_checks++;
        if (wr_cnt != exp_wr) begin
            n_fail++;
            $display("FAIL %s mem_we_pulses: got %0d want %0d", name, wr_cnt, exp_wr);
        end
        if (exp_wr == 1) begin
            n_checks++;
            if (got_wd !== model_mem[idx]) begin
                n_fail++;
                $display("FAIL %s mem_wd: got %h want %h", name, got_wd, model_mem[idx]);
            end
        end
        n_checks++;
        if (a_bad || rdy_bad) begin
            n_fail++;
            $display("FAIL %s busy_mem_a_ready: got a_bad=%0d rdy_bad=%0d want 0 0",
                     name, a_bad, rdy_bad);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.req_ready} !==
            {1'b0, 1'b0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL %s after_resp: got v=%b e=%b d=%h r=%b want 0 0 0 1", name,
                     bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.req_ready);
        end
        if (idx < 16) begin
            n_checks++;
            if (ram[idx] !== model_mem[idx]) begin
                n_fail++;
                $display("FAIL %s ram: got %h want %h", name, ram[idx], model_mem[idx]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.mem_we,
             bus.mem_a, bus.mem_wd} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got r=%b v=%b d=%h e=%b we=%b a=%h wd=%h want 1 0 0 0 0 0 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.mem_we,
                     bus.mem_a, bus.mem_wd);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got r=%b v=%b want 1 0", bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_directed();
        poke(3, 32'h8001_7F80);
        do_req("ldb_signed", 1'b0, 2'b00, 1'b0, 32'h0C, 32'h0);
        n_checks++;
        if (last_rd !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL ldb_signed_const: got %h want FFFFFF80", last_rd);
        end
        do_req("ldb_unsigned", 1'b0, 2'b00, 1'b1, 32'h0C, 32'h0);
        n_checks++;
        if (last_rd !== 32'h0000_0080) begin
            n_fail++;
            $display("FAIL ldb_unsigned_const: got %h want 00000080", last_rd);
        end
        do_req("ldh_signed", 1'b0, 2'b01, 1'b0, 32'h0E, 32'h0);
        n_checks++;
        if (last_rd !== 32'hFFFF_8001) begin
            n_fail++;
            $display("FAIL ldh_signed_const: got %h want FFFF8001", last_rd);
        end
        do_req("ldw", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
        n_checks++;
        if (last_rd !== 32'h8001_7F80) begin
            n_fail++;
            $display("FAIL ldw_const: got %h want 80017F80", last_rd);
        end
        poke(1, 32'h1122_3344);
        do_req("stb_rmw", 1'b1, 2'b00, 1'b0, 32'h06, 32'h0000_00AB);
        do_req("ldw_after_stb", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
        n_checks++;
        if (last_rd !== 32'h11AB_3344) begin
            n_fail++;
            $display("FAIL ldw_after_stb_const: got %h want 11AB3344", last_rd);
        end
    endtask

    task automatic test_errors();
        do_req("err_ldh_mis", 1'b0, 2'b01, 1'b0, 32'h05, 32'h0);
        do_req("err_stw_mis", 1'b1, 2'b10, 1'b0, 32'h0A, 32'h1234_5678);
        do_req("err_range", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        n_checks++;
        if (last_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_range_const: got %b want 1", last_err);
        end
        do_req("err_rsvd", 1'b1, 2'b11, 1'b0, 32'h00, 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) poke(i, $urandom);
        for (int i = 0; i < 40; i++) begin
            do_req("random", 1'($urandom), 2'($urandom), 1'($urandom),
                   32'($urandom_range(0, 79)), $urandom);
        end
    endtask

    task automatic test_back_to_back();
        logic e1, e2;
        logic [31:0] r1, r2, rd2;
        int l1, l2, w1, w2, low_cnt, ready_cycle, resp1, resp2;
        bit seen_ready;
        poke(2, 32'h0);
        model_req(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF, e1, r1, l1, w1);
        model_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, e2, r2, l2, w2);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h08;
        bus.req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.req_we = 1'b0;
        bus.req_wdata = 32'h0;
        low_cnt = 0;
        ready_cycle = 0;
        resp1 = 0;
        resp2 = 0;
        rd2 = 32'h0;
        seen_ready = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (!seen_ready) begin
                if (bus.req_ready === 1'b0) low_cnt++;
                else begin
                    seen_ready = 1;
                    ready_cycle = c;
                end
            end
            if (bus.resp_valid === 1'b1) begin
                if (resp1 == 0) resp1 = c;
                else begin
                    resp2 = c;
                    rd2 = bus.resp_rdata;
                end
            end
            @(posedge clk);
            if (c == ready_cycle) #1 bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        n_checks++;
        if (low_cnt != l1) begin
            n_fail++;
            $display("FAIL b2b_ready_low: got %0d want %0d", low_cnt, l1);
        end
        n_checks++;
        if (resp1 != l1) begin
            n_fail++;
            $display("FAIL b2b_resp1_cycle: got %0d want %0d", resp1, l1);
        end
        n_checks++;
        if (resp2 != l1 + 1 + l2) begin
            n_fail++;
            $display("FAIL b2b_resp2_cycle: got %0d want %0d", resp2, l1 + 1 + l2);
        end
        n_checks++;
        if (rd2 !== r2 || rd2 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL b2b_resp2_data: got %h want %h", rd2, r2);
        end
        n_checks++;
        if (ram[2] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL b2b_ram: got %h want DEADBEEF", ram[2]);
        end
    endtask

    task automatic test_reset_mid();
        bit we_seen, resp_seen;
        poke(2, 32'h5566_7788);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h09;
        bus.req_wdata = 32'h0000_00AB;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_we !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: got we=%b r=%b v=%b want 0 1 0",
                     bus.mem_we, bus.req_ready, bus.resp_valid);
        end
        we_seen = 0;
        resp_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.mem_we !== 1'b0) we_seen = 1;
            if (bus.resp_valid !== 1'b0) resp_seen = 1;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.mem_we !== 1'b0) we_seen = 1;
            if (bus.resp_valid !== 1'b0) resp_seen = 1;
        end
        n_checks++;
        if (we_seen || resp_seen) begin
            n_fail++;
            $display("FAIL midreset_quiet: got we_seen=%0d resp_seen=%0d want 0 0",
                     we_seen, resp_seen);
        end
        n_checks++;
        if (ram[2] !== 32'h5566_7788) begin
            n_fail++;
            $display("FAIL midreset_ram: got %h want 55667788", ram[2]);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        for (int i = 0; i < 16; i++) begin
            ram[i] = 32'h0;
            model_mem[i] = 32'h0;
        end
        test_reset();
        test_directed();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
